// File: rtl/regfile_sweep.sv
// regfile_sweep: DEPTH x DATA_W register file with two read ports (A, B) and
// one write port. After reset an init sweep loads every entry, one per cycle,
// and holds busy high until the last entry is written. Read ports support
// write-through forwarding and an optional one-cycle output register.
module regfile_sweep #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int ZERO_REG   = 1,
   parameter int INIT_INDEX = 1,
   parameter int BYPASS     = 1,
   parameter int READ_LAT   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] writedata,
   input  logic              regwrite,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      SWEEP = 1'b0,
      READY = 1'b1
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   idx_q;
   logic                busy_q;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W-1:0]   init_val;
   logic                rd_is_r0;
   logic                fwd_en;
   logic [DATA_W-1:0]   rd_a;
   logic [DATA_W-1:0]   rd_b;

   // Sweep value for the current index: the index itself, resized to DATA_W.
   assign init_val = (INIT_INDEX != 0) ? DATA_W'(idx_q) : '0;

   // A write to entry 0 is swallowed when entry 0 is hard-wired to zero.
   assign rd_is_r0 = (ZERO_REG != 0) && (rd == '0);

   // Forwarding only applies to writes that will actually land in storage.
   assign fwd_en = (BYPASS != 0) && (state_q == READY) && regwrite && !rd_is_r0;

   // Sweep controller: walk idx over every entry, then hand over to normal use.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= SWEEP;
         idx_q   <= '0;
         busy_q  <= 1'b1;
      end else if (state_q == SWEEP) begin
         idx_q <= idx_q + ADDR_W'(1);
         if (&idx_q) begin
            state_q <= READY;
            busy_q  <= 1'b0;
         end
      end
   end

   // Write-port select: the sweep owns the port until READY.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      wr_en   = 1'b0;
      wr_addr = rd;
      wr_data = writedata;
      if (state_q == SWEEP) begin
         wr_en   = !reset;
         wr_addr = idx_q;
         wr_data = init_val;
      end else begin
         wr_en = regwrite && !rd_is_r0;
      end
   end

   // Storage array, one write per cycle.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; the sweep initialises it, so a reset term
      // here would only turn the RAM into a flop bank.
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read mux: zero register beats forwarding, forwarding beats storage, and
   // nothing but zero leaves while the sweep is running.
   function automatic logic [DATA_W-1:0] read_mux(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              blocked,
      input logic              fwd,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] val;
      val = stored;
      if (fwd && (waddr == addr)) begin
         val = wdata;
      end
      if (blocked || ((ZERO_REG != 0) && (addr == '0))) begin
         val = '0;
      end
      return val;
   endfunction

   // Combinational read data for both ports.
   always_comb begin
      rd_a = read_mux(rs, mem_q[rs], busy_q, fwd_en, rd, writedata);
      rd_b = read_mux(rt, mem_q[rt], busy_q, fwd_en, rd, writedata);
   end

   generate
      if (READ_LAT != 0) begin : g_read_reg
         logic [DATA_W-1:0] a_q;
         logic [DATA_W-1:0] b_q;

         // Output registers: capture this cycle's read so it appears next cycle.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= rd_a;
               b_q <= rd_b;
            end
         end

         assign A = a_q;
         assign B = b_q;
      end else begin : g_read_comb
         assign A = rd_a;
         assign B = rd_b;
      end
   endgenerate

   assign busy = busy_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Bench for regfile_sweep: three configurations share one stimulus stream
// (defaults; ZERO_REG=0; READ_LAT=1 with BYPASS=0) and are compared every
// cycle against an array-based model, plus directed literal checks.
module tb_regfile_sweep;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rs, rt, rd;
   logic [DW-1:0] writedata;
   logic          regwrite;

   logic [DW-1:0] a_def, b_def, a_z0, b_z0, a_l1, b_l1;
   logic          busy_def, busy_z0, busy_l1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   regfile_sweep dut_def (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
      .writedata(writedata), .regwrite(regwrite),
      .A(a_def), .B(b_def), .busy(busy_def)
   );

   regfile_sweep #(.ZERO_REG(0)) dut_z0 (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
      .writedata(writedata), .regwrite(regwrite),
      .A(a_z0), .B(b_z0), .busy(busy_z0)
   );

   regfile_sweep #(.READ_LAT(1), .BYPASS(0)) dut_l1 (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd),
      .writedata(writedata), .regwrite(regwrite),
      .A(a_l1), .B(b_l1), .busy(busy_l1)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Sweep is a countdown of remaining busy cycles; when it reaches zero every
   // entry holds its own index. mem1 models ZERO_REG=1 storage, mem0 ZERO_REG=0.
   int            remaining = DEPTH;
   logic [DW-1:0] mem1 [DEPTH];
   logic [DW-1:0] mem0 [DEPTH];
   logic [DW-1:0] lat_a = '0;
   logic [DW-1:0] lat_b = '0;

   function automatic logic [DW-1:0] exp_rd(input int addr, input bit zr, input bit byp);
      if (remaining > 0) return '0;
      if (zr && addr == 0) return '0;
      if (byp && regwrite && int'(rd) == addr) return writedata;
      return zr ? mem1[addr] : mem0[addr];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining = DEPTH;
         lat_a     = '0;
         lat_b     = '0;
      end else begin
         lat_a = exp_rd(int'(rs), 1'b1, 1'b0);
         lat_b = exp_rd(int'(rt), 1'b1, 1'b0);
         if (remaining == 0) begin
            if (regwrite) begin
               if (rd != '0) mem1[rd] = writedata;
               mem0[rd] = writedata;
            end
         end else begin
            remaining--;
            if (remaining == 0) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem1[i] = DW'(i);
                  mem0[i] = DW'(i);
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy_def", DW'(busy_def), DW'(remaining > 0));
         check("busy_z0",  DW'(busy_z0),  DW'(remaining > 0));
         check("busy_l1",  DW'(busy_l1),  DW'(remaining > 0));
         check("A_def", a_def, exp_rd(int'(rs), 1'b1, 1'b1));
         check("B_def", b_def, exp_rd(int'(rt), 1'b1, 1'b1));
         check("A_z0",  a_z0,  exp_rd(int'(rs), 1'b0, 1'b1));
         check("B_z0",  b_z0,  exp_rd(int'(rt), 1'b0, 1'b1));
         check("A_l1",  a_l1,  lat_a);
         check("B_l1",  b_l1,  lat_b);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered one time unit after reset release (idx=0 at iteration k=0).
   // inject_k: cycle to attempt a write of 0xFF to entry 20 while busy.
   // abort_k: cycle at which reset is re-asserted (task returns with reset high).
   task automatic run_sweep(input int inject_k, input int abort_k, output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         if (k == abort_k) begin
            reset = 1'b1;
            #1;
            check("abort_busy", DW'(busy_def), 32'd1);
            check("abort_A", a_def, 32'd0);
            check("abort_B_l1", b_l1, 32'd0);
            return;
         end
         regwrite = (k == inject_k);
         if (k == inject_k) begin
            rd = 5'd20; writedata = 32'h0000_00FF; rs = 5'd20; rt = 5'd20;
         end
         @(negedge clk);
         if (busy_def !== 1'b1) break;
         n++;
         if (k == inject_k) begin
            check("T4_busy_A", a_def, 32'd0);
            check("T4_busy_B", b_def, 32'd0);
            check("T4_busy_A_z0", a_z0, 32'd0);
         end
         step();
      end
      regwrite = 1'b0;
      step();
   endtask

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
   } vec_t;

   vec_t vecs [5];
   int   n;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rs = '0; rt = '0; rd = '0; writedata = '0; regwrite = 1'b0;
      vecs[0] = '{5'd31, 32'hCAFE_F00D, 5'd31, 5'd9};
      vecs[1] = '{5'd9,  32'h1357_9BDF, 5'd31, 5'd9};
      vecs[2] = '{5'd17, 32'hFFFF_FFFF, 5'd17, 5'd17};
      vecs[3] = '{5'd1,  32'h0000_0000, 5'd1,  5'd31};
      vecs[4] = '{5'd0,  32'h8000_0001, 5'd9,  5'd0};
      #1 chk_en = 1'b1;

      // T1 + T4: reset two cycles, count busy, ignored write at idx=10.
      step(); step();
      check("reset_busy", DW'(busy_def), 32'd1);
      check("reset_A", a_def, 32'd0);
      reset = 1'b0;
      run_sweep(10, -1, n);
      check("T1_busy_cycles", DW'(n), 32'd32);

      rs = 5'd20; rt = 5'd7;
      @(negedge clk);
      check("T4_A20", a_def, 32'd20);
      check("T4_B7", b_def, 32'd7);
      step();

      rs = 5'd7; rt = 5'd31;
      @(negedge clk);
      check("T1_A7", a_def, 32'd7);
      check("T1_B31", b_def, 32'd31);
      step();

      // T2: bypass then stored value.
      rd = 5'd5; writedata = 32'hDEAD_BEEF; regwrite = 1'b1; rs = 5'd5; rt = 5'd6;
      @(negedge clk);
      check("T2_bypass_A", a_def, 32'hDEAD_BEEF);
      check("T2_B6", b_def, 32'd6);
      step();
      regwrite = 1'b0;
      @(negedge clk);
      check("T2_stored_A", a_def, 32'hDEAD_BEEF);
      step();

      // T3: writes to entry 0.
      rd = 5'd0; writedata = 32'h0000_1234; regwrite = 1'b1; rs = 5'd0; rt = 5'd0;
      @(negedge clk);
      check("T3_A_zr", a_def, 32'd0);
      check("T3_B_zr", b_def, 32'd0);
      check("T3_A_nozr", a_z0, 32'h0000_1234);
      check("T3_B_nozr", b_z0, 32'h0000_1234);
      step();
      regwrite = 1'b0;
      @(negedge clk);
      check("T3_A_zr_next", a_def, 32'd0);
      check("T3_A_nozr_next", a_z0, 32'h0000_1234);
      step();

      // T6: registered read without bypass.
      rd = 5'd3; writedata = 32'h0000_00A5; regwrite = 1'b1; rs = 5'd3; rt = 5'd3;
      @(negedge clk);
      check("T6_def_bypass", a_def, 32'h0000_00A5);
      step();
      regwrite = 1'b0;
      @(negedge clk);
      check("T6_lat_old", a_l1, 32'd3);
      step();
      @(negedge clk);
      check("T6_lat_new", a_l1, 32'h0000_00A5);
      step();

      // Directed write/read vectors, checked by the model each cycle.
      foreach (vecs[i]) begin
         rd = vecs[i].rd; writedata = vecs[i].data; rs = vecs[i].rs; rt = vecs[i].rt;
         regwrite = 1'b1;
         step();
         regwrite = 1'b0;
         step();
      end
      rs = 5'd9; rt = 5'd31;
      @(negedge clk);
      check("vec_A9", a_def, 32'h1357_9BDF);
      check("vec_B31", b_def, 32'hCAFE_F00D);
      step();

      // T5: reset in READY, abort sweep at idx=16, full resweep.
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      run_sweep(-1, 16, n);
      step(); step();
      rs = 5'd7; rt = 5'd5;
      reset = 1'b0;
      run_sweep(-1, -1, n);
      check("T5_busy_cycles", DW'(n), 32'd32);
      @(negedge clk);
      check("T5_A7", a_def, 32'd7);
      check("T5_B5_reloaded", b_def, 32'd5);
      step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
